// File: rtl/axi_multichain_prewrapper_pkg.sv
// Shared types and register map for axi_multichain_prewrapper.
// Holds the FSM state encoding, word addresses, CTRL bit indices and STATUS field positions.
package axi_wrap_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_DUT_REQ    = 3'd1,
    S_DUT_WAIT   = 3'd2,
    S_DUT_ACK    = 3'd3,
    S_DFT_REQ    = 3'd4,
    S_DFT_STREAM = 3'd5,
    S_DFT_ACK    = 3'd6
  } state_t;

  localparam logic [31:0] ADDR_CTRL     = 32'h0000_0000;
  localparam logic [31:0] ADDR_STATUS   = 32'h0000_0001;
  localparam logic [31:0] ADDR_DIN      = 32'h0000_0002;
  localparam logic [31:0] ADDR_DOUT     = 32'h0000_0003;
  localparam logic [31:0] ADDR_BUF_BASE = 32'h0000_0100;

  localparam int unsigned CTRL_START_DUT = 0;
  localparam int unsigned CTRL_START_DFT = 1;
  localparam int unsigned CTRL_CLEAR     = 2;

  localparam int unsigned STAT_STATE_LSB = 0;
  localparam int unsigned STAT_DUT_DONE  = 3;
  localparam int unsigned STAT_DFT_DONE  = 4;
  localparam int unsigned STAT_OVERFLOW  = 5;
  localparam int unsigned STAT_BUSY_ERR  = 6;
  localparam int unsigned STAT_TIMEOUT   = 7;
  localparam int unsigned STAT_COUNT_LSB = 8;

  // Word count can reach 256 for the deepest buffer; the STATUS field is 8 bits.
  function automatic logic [7:0] sat_count(input logic [8:0] cnt);
    return cnt[8] ? 8'hFF : cnt[7:0];
  endfunction

endpackage

// File: rtl/axi_multichain_prewrapper_dump_buffer.sv
// One scan-chain capture buffer: P_DEPTH x 32 RAM, single write port,
// synchronous read port. Contents are not reset.
module dump_buffer #(
  parameter int unsigned P_DEPTH = 32,
  parameter int unsigned P_AW    = 5
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [P_AW-1:0] wr_addr,
  input  logic [31:0]     wr_data,
  input  logic [P_AW-1:0] rd_addr,
  output logic [31:0]     rd_data
);

  logic [31:0] mem [P_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/axi_multichain_prewrapper.sv
// AXI register bridge sequencing one DUT channel and P_SC_NBR scan-chain dumps.
// Optional watchdog on REQ/WAIT/STREAM states enabled by macro AXI_WRAP_TIMEOUT_EN.
module axi_multichain_prewrapper
  import axi_wrap_pkg::*;
#(
  parameter int unsigned P_SC_NBR    = 1,
  parameter int unsigned P_DUT_IN_W  = 32,
  parameter int unsigned P_DUT_OUT_W = 32,
  parameter int unsigned P_DEPTH     = 32,
  parameter int unsigned P_TIMEOUT   = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    axi_wr_val,
  input  logic [31:0]             axi_wr_addr,
  input  logic [31:0]             axi_wr_msg,
  input  logic [31:0]             axi_rd_addr,
  output logic [31:0]             axi_rd_msg,
  output logic [P_DUT_IN_W-1:0]   dut_input_vec,
  input  logic [P_DUT_OUT_W-1:0]  dut_output_vec,
  output logic                    dut_val_op,
  input  logic                    dut_op_ack,
  input  logic                    dut_op_commit,
  output logic                    dut_commit_ack,
  output logic                    dut_sen,
  input  logic [32*P_SC_NBR-1:0]  dft_output_data,
  output logic                    dft_val_op,
  input  logic                    dft_op_ack,
  input  logic                    dft_output_strobe,
  input  logic                    dft_op_commit,
  output logic                    dft_commit_ack
);

  localparam int unsigned AW = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;
  localparam int unsigned PW = $clog2(P_DEPTH + 1);
  localparam int unsigned CW = (P_SC_NBR > 1) ? $clog2(P_SC_NBR) : 1;
  localparam logic [31:0] BUF_SPAN = 32'(P_SC_NBR * P_DEPTH);

  state_t                 state, state_nxt;
  logic [PW-1:0]          ptr;
  logic                   dut_done, dft_done, overflow, busy_err, timeout;
  logic [P_DUT_IN_W-1:0]  din_q;
  logic [P_DUT_OUT_W-1:0] dout_q;

  logic ctrl_wr, start_dut, start_dft, clear_req, is_idle;
  logic go_dut, go_dft, do_clear, busy_hit;
  logic strobe_in, buf_we, ovf_hit, wd_expire;

  assign ctrl_wr   = axi_wr_val && (axi_wr_addr == ADDR_CTRL);
  assign start_dut = ctrl_wr && axi_wr_msg[CTRL_START_DUT];
  assign start_dft = ctrl_wr && axi_wr_msg[CTRL_START_DFT];
  assign clear_req = ctrl_wr && axi_wr_msg[CTRL_CLEAR];
  assign is_idle   = (state == S_IDLE);
  // A combined start runs the DUT only; the DFT request is discarded.
  assign go_dut    = is_idle && start_dut;
  assign go_dft    = is_idle && start_dft && !start_dut;
  assign do_clear  = is_idle && clear_req;
  assign busy_hit  = !is_idle && (start_dut || start_dft || clear_req);

  assign strobe_in = (state == S_DFT_STREAM) && dft_output_strobe;
  assign buf_we    = strobe_in && (ptr != PW'(P_DEPTH));
  assign ovf_hit   = strobe_in && (ptr == PW'(P_DEPTH));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    dut_val_op     = 1'b0;
    dut_commit_ack = 1'b0;
    dut_sen        = 1'b0;
    dft_val_op     = 1'b0;
    dft_commit_ack = 1'b0;
    case (state)
      S_IDLE: begin
        if (go_dut)      state_nxt = S_DUT_REQ;
        else if (go_dft) state_nxt = S_DFT_REQ;
      end
      S_DUT_REQ: begin
        dut_val_op = 1'b1;
        if (dut_op_ack) state_nxt = S_DUT_WAIT;
      end
      S_DUT_WAIT: begin
        if (dut_op_commit) state_nxt = S_DUT_ACK;
      end
      S_DUT_ACK: begin
        dut_commit_ack = 1'b1;
        state_nxt      = S_IDLE;
      end
      S_DFT_REQ: begin
        dft_val_op = 1'b1;
        dut_sen    = 1'b1;
        if (dft_op_ack) state_nxt = S_DFT_STREAM;
      end
      S_DFT_STREAM: begin
        dut_sen = 1'b1;
        if (dft_op_commit) state_nxt = S_DFT_ACK;
      end
      S_DFT_ACK: begin
        dft_commit_ack = 1'b1;
        state_nxt      = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (wd_expire) state_nxt = S_IDLE;
  end

`ifdef AXI_WRAP_TIMEOUT_EN
  localparam int unsigned TW = $clog2(P_TIMEOUT + 1);
  logic [TW-1:0] wd_cnt;
  logic          wd_active;

  assign wd_active = state inside {S_DUT_REQ, S_DUT_WAIT, S_DFT_REQ, S_DFT_STREAM};
  assign wd_expire = wd_active && (wd_cnt == TW'(P_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset)                                 wd_cnt <= '0;
    else if ((state_nxt != state) || strobe_in) wd_cnt <= '0;
    else if (wd_active)                        wd_cnt <= wd_cnt + TW'(1);
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr      <= '0;
      dut_done <= 1'b0;
      dft_done <= 1'b0;
      overflow <= 1'b0;
      busy_err <= 1'b0;
      timeout  <= 1'b0;
      din_q    <= '0;
      dout_q   <= '0;
    end else begin
      if (axi_wr_val && (axi_wr_addr == ADDR_DIN)) din_q <= axi_wr_msg[P_DUT_IN_W-1:0];
      if ((state == S_DUT_WAIT) && dut_op_commit)  dout_q <= dut_output_vec;
      if (do_clear) begin
        ptr      <= '0;
        dut_done <= 1'b0;
        dft_done <= 1'b0;
        overflow <= 1'b0;
        busy_err <= 1'b0;
        timeout  <= 1'b0;
      end
      if (go_dut) dut_done <= 1'b0;
      if (go_dft) begin
        dft_done <= 1'b0;
        ptr      <= '0;
      end
      if (busy_hit)              busy_err <= 1'b1;
      if (buf_we)                ptr      <= ptr + PW'(1);
      if (ovf_hit)               overflow <= 1'b1;
      if (state == S_DUT_ACK)    dut_done <= 1'b1;
      if (state == S_DFT_ACK)    dft_done <= 1'b1;
      if (wd_expire)             timeout  <= 1'b1;
    end
  end

  assign dut_input_vec = din_q;

  logic [31:0]    reg_rd, reg_rd_q;
  logic [31:0]    rd_off;
  logic           rd_in_buf, rd_buf_q;
  logic [AW-1:0]  rd_word;
  logic [CW-1:0]  rd_chain, rd_chain_q;
  logic [31:0]    buf_rd [P_SC_NBR];
  logic           unused_rd_bits;

  always_comb begin
    reg_rd = '0;
    case (axi_rd_addr)
      ADDR_STATUS: reg_rd = {16'b0, sat_count(9'(ptr)), timeout, busy_err, overflow,
                             dft_done, dut_done, state};
      ADDR_DIN:    reg_rd = 32'(din_q);
      ADDR_DOUT:   reg_rd = 32'(dout_q);
      default:     reg_rd = '0;
    endcase
  end

  // Chain index sits directly above the word-offset bits of the buffer window.
  assign rd_off         = axi_rd_addr - ADDR_BUF_BASE;
  assign rd_in_buf      = (axi_rd_addr >= ADDR_BUF_BASE) && (rd_off < BUF_SPAN);
  assign rd_word        = rd_off[AW-1:0];
  assign rd_chain       = rd_off[AW +: CW];
  assign unused_rd_bits = ^rd_off[31:AW+CW];

  always_ff @(posedge clk) begin
    if (reset) begin
      reg_rd_q   <= '0;
      rd_buf_q   <= 1'b0;
      rd_chain_q <= '0;
    end else begin
      reg_rd_q   <= reg_rd;
      rd_buf_q   <= rd_in_buf;
      rd_chain_q <= rd_chain;
    end
  end

  assign axi_rd_msg = rd_buf_q ? buf_rd[rd_chain_q] : reg_rd_q;

  for (genvar c = 0; c < P_SC_NBR; c++) begin : g_chain
    dump_buffer #(
      .P_DEPTH (P_DEPTH),
      .P_AW    (AW)
    ) u_buf (
      .clk     (clk),
      .wr_en   (buf_we),
      .wr_addr (ptr[AW-1:0]),
      .wr_data (dft_output_data[32*c +: 32]),
      .rd_addr (rd_word),
      .rd_data (buf_rd[c])
    );
  end

endmodule

// File: tb/tb_axi_multichain_prewrapper.sv
// Directed self-checking bench for axi_multichain_prewrapper (4 chains, depth 32).
// Covers AXI_WRAP_TIMEOUT_EN (P_TIMEOUT=16) or the indefinite-wait default build.
module tb_axi_multichain_prewrapper;

  localparam int unsigned SC    = 4;
  localparam int unsigned DEPTH = 32;

  logic              clk;
  logic              reset;
  logic              axi_wr_val;
  logic [31:0]       axi_wr_addr, axi_wr_msg, axi_rd_addr, axi_rd_msg;
  logic [31:0]       dut_input_vec, dut_output_vec;
  logic              dut_val_op, dut_op_ack, dut_op_commit, dut_commit_ack, dut_sen;
  logic [32*SC-1:0]  dft_output_data;
  logic              dft_val_op, dft_op_ack, dft_output_strobe, dft_op_commit, dft_commit_ack;

  int unsigned total;
  int unsigned bad;

  axi_multichain_prewrapper #(
    .P_SC_NBR    (SC),
    .P_DUT_IN_W  (32),
    .P_DUT_OUT_W (32),
    .P_DEPTH     (DEPTH),
    .P_TIMEOUT   (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .axi_wr_val        (axi_wr_val),
    .axi_wr_addr       (axi_wr_addr),
    .axi_wr_msg        (axi_wr_msg),
    .axi_rd_addr       (axi_rd_addr),
    .axi_rd_msg        (axi_rd_msg),
    .dut_input_vec     (dut_input_vec),
    .dut_output_vec    (dut_output_vec),
    .dut_val_op        (dut_val_op),
    .dut_op_ack        (dut_op_ack),
    .dut_op_commit     (dut_op_commit),
    .dut_commit_ack    (dut_commit_ack),
    .dut_sen           (dut_sen),
    .dft_output_data   (dft_output_data),
    .dft_val_op        (dft_val_op),
    .dft_op_ack        (dft_op_ack),
    .dft_output_strobe (dft_output_strobe),
    .dft_op_commit     (dft_op_commit),
    .dft_commit_ack    (dft_commit_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] a, input logic [31:0] d);
    axi_wr_val  = 1'b1;
    axi_wr_addr = a;
    axi_wr_msg  = d;
    tick();
    axi_wr_val  = 1'b0;
    axi_wr_addr = '0;
    axi_wr_msg  = '0;
  endtask

  task automatic axi_read(input logic [31:0] a, output logic [31:0] d);
    axi_rd_addr = a;
    tick();
    d = axi_rd_msg;
  endtask

  task automatic test_reset();
    logic [31:0] r;
    reset = 1'b1;
    repeat (3) tick();
    total++;
    if ({dut_val_op, dut_commit_ack, dut_sen, dft_val_op, dft_commit_ack} !== 5'b0) begin
      bad++;
      $display("FAIL reset_hs: got %b want 00000",
               {dut_val_op, dut_commit_ack, dut_sen, dft_val_op, dft_commit_ack});
    end
    total++;
    if (axi_rd_msg !== 32'h0 || dut_input_vec !== 32'h0) begin
      bad++;
      $display("FAIL reset_data: got rd=%h din=%h want 0", axi_rd_msg, dut_input_vec);
    end
    reset = 1'b0;
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_status: got %h want 00000000", r); end
    axi_read(32'h3, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_dout: got %h want 00000000", r); end
  endtask

  task automatic test_dut_op();
    logic [31:0] r;
    int unsigned pulses;
    axi_write(32'h2, 32'hDEAD_BEEF);
    axi_write(32'h0, 32'h1);
    total++;
    if (dut_val_op !== 1'b1) begin bad++; $display("FAIL dut_val_first: got %b want 1", dut_val_op); end
    repeat (2) tick();
    dut_op_ack = 1'b1;
    tick();
    dut_op_ack = 1'b0;
    total++;
    if (dut_val_op !== 1'b0) begin bad++; $display("FAIL dut_val_drop: got %b want 0", dut_val_op); end
    repeat (4) tick();
    dut_output_vec = 32'h1234_5678;
    dut_op_commit  = 1'b1;
    tick();
    dut_op_commit  = 1'b0;
    dut_output_vec = 32'hFFFF_FFFF;
    pulses = 0;
    for (int k = 0; k < 6; k++) begin
      if (dut_commit_ack === 1'b1) pulses++;
      tick();
    end
    total++;
    if (pulses != 1) begin bad++; $display("FAIL dut_commit_pulses: got %0d want 1", pulses); end
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_0008) begin bad++; $display("FAIL dut_status: got %h want 00000008", r); end
    axi_read(32'h3, r);
    total++;
    if (r !== 32'h1234_5678) begin bad++; $display("FAIL dut_dout: got %h want 12345678", r); end
    axi_read(32'h2, r);
    total++;
    if (r !== 32'hDEAD_BEEF || dut_input_vec !== 32'hDEAD_BEEF) begin
      bad++;
      $display("FAIL dut_din: got rd=%h vec=%h want deadbeef", r, dut_input_vec);
    end
  endtask

  task automatic test_dft_dump();
    logic [31:0] r;
    axi_write(32'h0, 32'h2);
    total++;
    if ({dft_val_op, dut_sen, dut_val_op} !== 3'b110) begin
      bad++;
      $display("FAIL dft_req: got %b want 110", {dft_val_op, dut_sen, dut_val_op});
    end
    dft_op_ack = 1'b1;
    tick();
    dft_op_ack = 1'b0;
    total++;
    if ({dft_val_op, dut_sen} !== 2'b01) begin
      bad++;
      $display("FAIL dft_stream: got %b want 01", {dft_val_op, dut_sen});
    end
    // last strobe coincides with commit
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < int'(SC); c++) dft_output_data[32*c +: 32] = 32'((c << 8) | i);
      dft_output_strobe = 1'b1;
      dft_op_commit     = (i == 9);
      tick();
    end
    dft_output_strobe = 1'b0;
    dft_op_commit     = 1'b0;
    total++;
    if ({dft_commit_ack, dut_sen} !== 2'b10) begin
      bad++;
      $display("FAIL dft_ack: got %b want 10", {dft_commit_ack, dut_sen});
    end
    tick();
    total++;
    if (dft_commit_ack !== 1'b0) begin bad++; $display("FAIL dft_ack_single: got %b want 0", dft_commit_ack); end
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_0A18) begin bad++; $display("FAIL dft_status: got %h want 00000a18", r); end
    for (int c = 0; c < int'(SC); c++) begin
      for (int i = 0; i < 10; i++) begin
        axi_read(32'(32'h100 + c * DEPTH + i), r);
        total++;
        if (r !== 32'((c << 8) | i)) begin
          bad++;
          $display("FAIL dft_buf c%0d w%0d: got %h want %h", c, i, r, 32'((c << 8) | i));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic [31:0] r;
    axi_write(32'h0, 32'h2);
    dft_op_ack = 1'b1;
    tick();
    dft_op_ack = 1'b0;
    for (int k = 0; k < 40; k++) begin
      for (int c = 0; c < int'(SC); c++) dft_output_data[32*c +: 32] = 32'((c << 16) | k);
      dft_output_strobe = 1'b1;
      tick();
    end
    dft_output_strobe = 1'b0;
    dft_op_commit = 1'b1;
    tick();
    dft_op_commit = 1'b0;
    tick();
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_2038) begin bad++; $display("FAIL ovf_status: got %h want 00002038", r); end
    for (int c = 0; c < int'(SC); c++) begin
      axi_read(32'(32'h100 + c * DEPTH + 31), r);
      total++;
      if (r !== 32'((c << 16) | 31)) begin
        bad++;
        $display("FAIL ovf_word31 c%0d: got %h want %h", c, r, 32'((c << 16) | 31));
      end
      axi_read(32'(32'h100 + c * DEPTH), r);
      total++;
      if (r !== 32'(c << 16)) begin
        bad++;
        $display("FAIL ovf_word0 c%0d: got %h want %h", c, r, 32'(c << 16));
      end
    end
  endtask

  task automatic test_busy();
    logic [31:0] r;
    int unsigned dft_seen;
    axi_write(32'h0, 32'h3);
    total++;
    if ({dut_val_op, dft_val_op} !== 2'b10) begin
      bad++;
      $display("FAIL both_start: got %b want 10", {dut_val_op, dft_val_op});
    end
    dut_op_ack = 1'b1;
    tick();
    dut_op_ack = 1'b0;
    axi_write(32'h0, 32'h2);
    dft_seen = 0;
    for (int k = 0; k < 3; k++) begin
      if (dft_val_op !== 1'b0) dft_seen++;
      tick();
    end
    total++;
    if (dft_seen != 0) begin bad++; $display("FAIL busy_no_dft: got %0d want 0", dft_seen); end
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_2072) begin bad++; $display("FAIL busy_status: got %h want 00002072", r); end
    dut_output_vec = 32'hA5A5_0001;
    dut_op_commit  = 1'b1;
    tick();
    dut_op_commit  = 1'b0;
    tick();
  endtask

  task automatic test_clear();
    logic [31:0] r;
    axi_write(32'h0, 32'h4);
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL clear_status: got %h want 00000000", r); end
    axi_read(32'(32'h100 + 2 * DEPTH + 31), r);
    total++;
    if (r !== 32'h0002_001F) begin bad++; $display("FAIL clear_keep_buf: got %h want 0002001f", r); end
    axi_write(32'h0, 32'h1);
    axi_write(32'h0, 32'h4);
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_0041) begin bad++; $display("FAIL clear_busy: got %h want 00000041", r); end
    dut_op_ack = 1'b1;
    tick();
    dut_op_ack = 1'b0;
    dut_op_commit = 1'b1;
    tick();
    dut_op_commit = 1'b0;
    tick();
    axi_write(32'h0, 32'h4);
  endtask

  task automatic test_unmapped();
    logic [31:0] r;
    axi_write(32'h7, 32'h1234_5678);
    axi_read(32'h4, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL unmapped_rd: got %h want 00000000", r); end
    axi_read(32'(32'h100 + SC * DEPTH), r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL past_buf_rd: got %h want 00000000", r); end
    axi_read(32'h0, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL ctrl_rd: got %h want 00000000", r); end
    axi_read(32'h2, r);
    total++;
    if (r !== 32'hDEAD_BEEF) begin bad++; $display("FAIL unmapped_wr: got %h want deadbeef", r); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] r;
    axi_write(32'h0, 32'h2);
    dft_op_ack = 1'b1;
    tick();
    dft_op_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      dft_output_strobe = 1'b1;
      tick();
    end
    dft_output_strobe = 1'b0;
    axi_rd_addr = 32'h2;
    tick();
    reset = 1'b1;
    tick();
    total++;
    if ({dut_val_op, dut_commit_ack, dut_sen, dft_val_op, dft_commit_ack} !== 5'b0 ||
        axi_rd_msg !== 32'h0 || dut_input_vec !== 32'h0) begin
      bad++;
      $display("FAIL reset_mid: got hs=%b rd=%h din=%h want 0",
               {dut_val_op, dut_commit_ack, dut_sen, dft_val_op, dft_commit_ack},
               axi_rd_msg, dut_input_vec);
    end
    reset = 1'b0;
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0) begin bad++; $display("FAIL reset_mid_status: got %h want 00000000", r); end
  endtask

  task automatic test_timeout();
    logic [31:0] r;
    axi_write(32'h0, 32'h1);
`ifdef AXI_WRAP_TIMEOUT_EN
    repeat (15) tick();
    total++;
    if (dut_val_op !== 1'b1) begin bad++; $display("FAIL wd_early: got %b want 1", dut_val_op); end
    tick();
    total++;
    if (dut_val_op !== 1'b0) begin bad++; $display("FAIL wd_expire: got %b want 0", dut_val_op); end
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_0080) begin bad++; $display("FAIL wd_status: got %h want 00000080", r); end
`else
    repeat (40) tick();
    total++;
    if (dut_val_op !== 1'b1) begin bad++; $display("FAIL no_wd_wait: got %b want 1", dut_val_op); end
    dut_op_ack = 1'b1;
    tick();
    dut_op_ack = 1'b0;
    dut_op_commit = 1'b1;
    tick();
    dut_op_commit = 1'b0;
    tick();
    axi_read(32'h1, r);
    total++;
    if (r !== 32'h0000_0008) begin bad++; $display("FAIL no_wd_status: got %h want 00000008", r); end
`endif
  endtask

  initial begin
    total             = 0;
    bad               = 0;
    reset             = 1'b1;
    axi_wr_val        = 1'b0;
    axi_wr_addr       = '0;
    axi_wr_msg        = '0;
    axi_rd_addr       = '0;
    dut_output_vec    = '0;
    dut_op_ack        = 1'b0;
    dut_op_commit     = 1'b0;
    dft_output_data   = '0;
    dft_op_ack        = 1'b0;
    dft_output_strobe = 1'b0;
    dft_op_commit     = 1'b0;
    test_reset();
    test_dut_op();
    test_dft_dump();
    test_overflow();
    test_busy();
    test_clear();
    test_unmapped();
    test_reset_mid();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_multichain_prewrapper.md
# axi_multichain_prewrapper

Parametrised successor to the single-chain prewrapper: bridges the word-addressed AXI register interface to one design-under-test (DUT) channel and up to 16 design-for-test (DFT) scan-chain channels. It sequences the DUT operation and DFT dump handshakes with a control FSM. Scan-out words are captured into per-chain on-chip buffers for later AXI readback. It sits between the AXI slave shim and `dft_top`.

## Interface
- `P_SC_NBR`, 1: scan chains captured, 1..16.
- `P_DUT_IN_W`, 32: DUT input vector width, ≤32.
- `P_DUT_OUT_W`, 32: DUT output vector width, ≤32.
- `P_DEPTH`, 32: words per chain buffer, power of 2, ≤256.
- `P_TIMEOUT`, 1024: watchdog limit in cycles (used only with the macro).
- `clk` in 1: single clock; all logic rising-edge.
- `reset` in 1: synchronous, active-high.
- `axi_wr_val` in 1: write strobe, one write per cycle it is high.
- `axi_wr_addr` in 32: write word address.
- `axi_wr_msg` in 32: write data.
- `axi_rd_addr` in 32: read word address.
- `axi_rd_msg` out 32: registered read data.
- `dut_input_vec` out P_DUT_IN_W: DUT operand.
- `dut_output_vec` in P_DUT_OUT_W: DUT result.
- `dut_val_op` out 1, `dut_op_ack` in 1, `dut_op_commit` in 1, `dut_commit_ack` out 1: DUT handshake.
- `dut_sen` out 1: scan enable.
- `dft_output_data` in 32·P_SC_NBR: chain c occupies bits [32c+31:32c].
- `dft_val_op` out 1, `dft_op_ack` in 1, `dft_output_strobe` in 1, `dft_op_commit` in 1, `dft_commit_ack` out 1: DFT handshake.

## Operation
- Register map, word addresses:
  - 0x0 CTRL, W. bit0 = START_DUT, bit1 = START_DFT, bit2 = CLEAR.
  - 0x1 STATUS, R. [2:0] state, [3] dut_done, [4] dft_done, [5] overflow, [6] busy_err, [7] timeout, [15:8] word count.
  - 0x2 DIN, R/W. Drives `dut_input_vec`.
  - 0x3 DOUT, R. Captured DUT result, zero-extended.
  - 0x100 + c·P_DEPTH + i, R. Chain c, word i.
- Unmapped reads return 0. Unmapped writes are ignored.
- FSM states: IDLE, DUT_REQ, DUT_WAIT, DUT_ACK, DFT_REQ, DFT_STREAM, DFT_ACK.
- DUT sequence:
  - IDLE + START_DUT → DUT_REQ: `dut_val_op`=1, held until `dut_op_ack`.
  - → DUT_WAIT: wait for `dut_op_commit`, then latch `dut_output_vec` into DOUT.
  - → DUT_ACK: `dut_commit_ack`=1 for exactly 1 cycle, set dut_done, → IDLE.
- DFT sequence:
  - IDLE + START_DFT → DFT_REQ: `dft_val_op`=1 and `dut_sen`=1 until `dft_op_ack`.
  - → DFT_STREAM: `dut_sen`=1. Each cycle with `dft_output_strobe` writes every chain's word at the write pointer, then increments the pointer.
  - `dft_op_commit` → DFT_ACK: `dft_commit_ack`=1 for 1 cycle, set dft_done, → IDLE.
- START_DUT and START_DFT in the same write: DUT runs; DFT is dropped, not queued.
- CTRL start while not IDLE: ignored; busy_err set (sticky).
- Strobe with pointer = P_DEPTH: data dropped, pointer saturates, overflow set (sticky).
- Strobe and commit in the same cycle: the word is stored, then → DFT_ACK.
- CLEAR: honoured only in IDLE. Zeroes the pointer and all sticky and done flags; buffer contents are retained. CLEAR while busy is ignored and sets busy_err.
- A new START_DFT zeroes the pointer and dft_done. A new START_DUT zeroes dut_done.
- Word count = pointer value, 0..P_DEPTH. It is reported in STATUS[15:8], which saturates at 255.
- Reset values: every output 0, state IDLE, all flags 0, DIN 0, DOUT 0. Buffer RAM is not reset.
- Reset mid-operation returns to IDLE next cycle with all handshake outputs low.

## Timing
- Read latency is 1 cycle: `axi_rd_msg` reflects `axi_rd_addr` from the prior edge.
- A CTRL write at edge N makes the state leave IDLE at N+1; `*_val_op` is first high in cycle N+1.
- `*_val_op` drops on the edge after ack is sampled.
- Buffer write occurs on the strobe edge, so a read of that word from the next cycle returns new data.
- Single-cycle `*_commit_ack` pulses.
- Back-to-back operations: IDLE lasts at least 1 cycle between them.

## Configuration
- `AXI_WRAP_TIMEOUT_EN` defined:
  - A watchdog counts cycles spent in any REQ, WAIT or STREAM state.
  - Reaching `P_TIMEOUT` drops all handshake outputs, sets timeout (sticky) and returns to IDLE without a commit ack.
  - The counter resets on every state change and on every strobe.
- `AXI_WRAP_TIMEOUT_EN` undefined: no counter, STATUS[7] reads 0, and the FSM waits indefinitely.

## Structure
- Package `axi_wrap_pkg` holds:
  - the state enum (3 bits);
  - register address constants: CTRL, STATUS, DIN, DOUT, BUF_BASE;
  - CTRL bit indices;
  - STATUS field positions.
- Sub-module `dump_buffer` is one P_DEPTH×32 synchronous-read RAM per chain, instantiated via generate over P_SC_NBR.
- The read mux selects the chain from address bits above log2(P_DEPTH).

## Test plan
- DUT op: write DIN=0xDEADBEEF and CTRL=0x1. Model acks after 3 cycles and commits 0x12345678 after 5 more. Required: STATUS.dut_done=1, DOUT=0x12345678, exactly one `dut_commit_ack` pulse.
- DFT dump, P_SC_NBR=4: 10 strobes with data chain<<8|i. Required: buffer(c,i) = chain<<8|i, word count=10, overflow=0.
- Overflow, P_DEPTH=32: 40 strobes. Required: word count=32, overflow=1, word 31 = the 32nd strobe's data.
- Write CTRL=0x3 from IDLE → DUT only. Then CTRL=0x2 while in DUT_WAIT → busy_err=1 and no `dft_val_op`.
- Reset asserted in DFT_STREAM → next cycle all outputs 0 and STATUS=0.
- With `AXI_WRAP_TIMEOUT_EN` and P_TIMEOUT=16, never ack → timeout=1 and IDLE after 16 cycles.
